// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and controller state type for the data_mem slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StErr1,
    StErr2
  } ctrl_state_e;

endpackage

// File: rtl/ahb_lane_merge.sv
// Little-endian sub-word merge: replaces the addressed byte lanes of old_i with hwdata lanes.
module ahb_lane_merge
  import ahb_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] merged_o
);

  logic [3:0] lane_en;

  always_comb begin
    case (size_i)
      HSIZE_BYTE: lane_en = 4'b0001 << off_i;
      HSIZE_HALF: lane_en = off_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_en = 4'b1111;
      default:    lane_en = 4'b0000;
    endcase
  end

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_mem_slave_ctrl.sv
// AHB-Lite slave sequencing a byte-addressable data_mem: wait states, range/alignment
// errors, and read-merge-write for sub-word stores.
module ahb_mem_slave_ctrl
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        wr_en_ram,
  output logic        rd_en_ram,
  output logic [31:0] address_ram,
  output logic [31:0] store_data,
  input  logic [31:0] read_data
);

  localparam logic [31:0] MemBytes = 32'(MEM_BYTES);
  localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic        hreadyout_q, hresp_q;

  logic [31:0] off;
  logic        accept;
  logic        addr_err;
  logic [31:0] merged;

  assign off    = haddr - BASE_ADDR;
  assign accept = hsel & hready & htrans[1];

  always_comb begin
    addr_err = (off >= MemBytes)
             || (hsize > HSIZE_WORD)
             || ((hsize == HSIZE_HALF) && off[0])
             || ((hsize == HSIZE_WORD) && (off[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        // IDLE, ACCESS and ERR2 all present hreadyout=1, so each may take a new transfer.
        state_d = StIdle;
        if (accept) begin
          addr_d  = off;
          write_d = hwrite;
          size_d  = hsize;
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StAccess;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= !((state_d == StWait) || (state_d == StErr1));
      hresp_q     <= ((state_d == StErr1) || (state_d == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  ahb_lane_merge u_lane_merge (
    .old_i    (read_data),
    .wdata_i  (hwdata),
    .size_i   (size_q),
    .off_i    (addr_q[1:0]),
    .merged_o (merged)
  );

  always_comb begin
    address_ram = {addr_q[31:2], 2'b00};
    rd_en_ram   = 1'b0;
    wr_en_ram   = 1'b0;
    hrdata      = 32'd0;
    store_data  = 32'd0;
    if (state_q == StAccess) begin
      rd_en_ram = 1'b1;
      if (write_q) begin
        wr_en_ram  = 1'b1;
        store_data = merged;
      end else begin
        hrdata = read_data;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave_ctrl.sv
// Randomized bench for ahb_mem_slave_ctrl: two instances (1 and 0 wait states), byte-level memory model.
module tb_ahb_mem_slave_ctrl;
  import ahb_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel [2];
  logic [31:0] haddr [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize [2];
  logic [31:0] hwdata [2];
  logic        hreadyout [2];
  logic        hresp [2];
  logic [31:0] hrdata [2];
  logic        wr_en_ram [2];
  logic        rd_en_ram [2];
  logic [31:0] address_ram [2];
  logic [31:0] store_data [2];
  logic [31:0] read_data [2];

  logic [31:0] ram [2][256] = '{default: '0};
  logic [7:0]  ref_mem [2][1024];
  xfer_t       seq_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  ahb_mem_slave_ctrl #(.BASE_ADDR(32'h0), .MEM_BYTES(1024), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hreadyout[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]), .wr_en_ram(wr_en_ram[0]),
    .rd_en_ram(rd_en_ram[0]), .address_ram(address_ram[0]), .store_data(store_data[0]),
    .read_data(read_data[0])
  );

  ahb_mem_slave_ctrl #(.BASE_ADDR(32'h0), .MEM_BYTES(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hreadyout[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]), .wr_en_ram(wr_en_ram[1]),
    .rd_en_ram(rd_en_ram[1]), .address_ram(address_ram[1]), .store_data(store_data[1]),
    .read_data(read_data[1])
  );

  // Backing data_mem per instance: combinational read, commit on the closing edge.
  assign read_data[0] = ram[0][address_ram[0][9:2]];
  assign read_data[1] = ram[1][address_ram[1][9:2]];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en_ram[d]) ram[d][address_ram[d][9:2]] <= store_data[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit ref_err(input xfer_t x);
    int unsigned nbytes;
    if (x.size > 3'd2) return 1'b1;
    if (x.addr >= 32'd1024) return 1'b1;
    nbytes = 1 << x.size;
    return (x.addr % nbytes) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] addr);
    int base;
    base = int'(addr[9:2]) * 4;
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  task automatic ref_write(input int d, input xfer_t x);
    int nbytes;
    int b;
    nbytes = 1 << x.size;
    for (int i = 0; i < nbytes; i++) begin
      b = int'(x.addr[9:0]) + i;
      ref_mem[d][b] = x.wdata[8*(b%4) +: 8];
    end
  endtask

  task automatic drive(input int d, input xfer_t x);
    hsel[d]   = x.sel;
    htrans[d] = x.trans;
    hwrite[d] = x.wr;
    haddr[d]  = x.addr;
    hsize[d]  = x.size;
  endtask

  task automatic push(input bit sel, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.addr = a; x.size = sz; x.wdata = wd;
    seq_q.push_back(x);
  endtask

  task automatic push_random();
    xfer_t x;
    int r;
    x.sel = ($urandom_range(0, 7) != 0);
    r = $urandom_range(0, 7);
    x.trans = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 5) ? HTRANS_NONSEQ : HTRANS_SEQ;
    x.wr = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 15);
    if (r == 0)      x.addr = 32'h400 + 32'($urandom_range(0, 1023));
    else if (r == 1) x.addr = $urandom();
    else             x.addr = 32'($urandom_range(0, 127));
    r = $urandom_range(0, 11);
    x.size = (r >= 9) ? 3'($urandom_range(3, 7)) : 3'(r % 3);
    x.wdata = $urandom();
    seq_q.push_back(x);
  endtask

  // Plays seq_q as a pipelined master on instance d, checking every data-phase cycle.
  task automatic run_seq(input int d);
    xfer_t cur;
    xfer_t idle_x;
    bit    busy = 1'b0;
    bit    e;
    bit    adv;
    int    lows = 0;
    int    idx = 0;
    int    guard = 0;
    idle_x.sel = 1'b0; idle_x.trans = HTRANS_IDLE; idle_x.wr = 1'b0;
    idle_x.addr = 32'd0; idle_x.size = HSIZE_WORD; idle_x.wdata = 32'd0;
    while ((idx < seq_q.size() || busy) && guard < 200) begin
      guard++;
      if (idx < seq_q.size()) drive(d, seq_q[idx]);
      else                    drive(d, idle_x);
      hwdata[d] = busy ? cur.wdata : $urandom();
      @(negedge clk);
      adv = hreadyout[d];
      if (busy) begin
        e = ref_err(cur);
        check("hresp", 32'(hresp[d]), 32'(e));
        if (!hreadyout[d]) begin
          lows++;
          check("rd_en_stall", 32'(rd_en_ram[d]), 32'd0);
          check("wr_en_stall", 32'(wr_en_ram[d]), 32'd0);
        end else begin
          check("stall_cycles", 32'(lows), e ? 32'd1 : 32'(ws_of(d)));
          check("rd_en_done", 32'(rd_en_ram[d]), 32'(!e));
          check("wr_en_done", 32'(wr_en_ram[d]), 32'(!e && cur.wr));
          if (!e && cur.wr) begin
            ref_write(d, cur);
            check("store_data", store_data[d], ref_word(d, cur.addr));
            check("address_ram", address_ram[d], {cur.addr[31:2], 2'b00});
          end
          if (!e && !cur.wr) check("hrdata", hrdata[d], ref_word(d, cur.addr));
          busy = 1'b0;
        end
      end else begin
        check("idle_ready", 32'(hreadyout[d]), 32'd1);
        check("idle_hresp", 32'(hresp[d]), 32'd0);
        check("idle_strobes", {30'd0, wr_en_ram[d], rd_en_ram[d]}, 32'd0);
        check("idle_hrdata", hrdata[d], 32'd0);
      end
      if (adv && idx < seq_q.size()) begin
        if (seq_q[idx].sel && seq_q[idx].trans[1]) begin
          cur  = seq_q[idx];
          busy = 1'b1;
          lows = 0;
        end
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("seq_complete", 32'(idx < seq_q.size() || busy), 32'd0);
    drive(d, idle_x);
    seq_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag, input int d);
    check({tag, "_hreadyout"}, 32'(hreadyout[d]), 32'd1);
    check({tag, "_hresp"}, 32'(hresp[d]), 32'd0);
    check({tag, "_hrdata"}, hrdata[d], 32'd0);
    check({tag, "_strobes"}, {30'd0, wr_en_ram[d], rd_en_ram[d]}, 32'd0);
    check({tag, "_address_ram"}, address_ram[d], 32'd0);
    check({tag, "_store_data"}, store_data[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
      haddr[d] = 32'd0; hsize[d] = HSIZE_WORD; hwdata[d] = 32'd0;
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por0", 0);
    check_reset_outputs("por1", 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: word write/read, byte merge, errors.
    push(1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF); run_seq(0);
    push(1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);        run_seq(0);
    push(1, HTRANS_NONSEQ, 1, 32'h13, HSIZE_BYTE, 32'hAA000000); run_seq(0);
    push(1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);        run_seq(0);
    check("merged_word", ref_word(0, 32'h10), 32'hAAADBEEF);
    push(1, HTRANS_NONSEQ, 1, 32'h11, HSIZE_HALF, 32'h5555_5555); run_seq(0);
    push(1, HTRANS_NONSEQ, 0, 32'h400, HSIZE_WORD, 32'h0);        run_seq(0);
    push(1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);         run_seq(0);
    push(1, HTRANS_BUSY, 1, 32'h10, HSIZE_WORD, 32'h0);
    push(1, HTRANS_IDLE, 1, 32'h10, HSIZE_WORD, 32'h0);
    run_seq(0);

    // Zero wait states, back-to-back write then read of the same word.
    push(1, HTRANS_NONSEQ, 1, 32'h20, HSIZE_WORD, 32'h12345678);
    push(1, HTRANS_SEQ,    0, 32'h20, HSIZE_WORD, 32'h0);
    push(1, HTRANS_NONSEQ, 1, 32'h22, HSIZE_HALF, 32'hCAFE0000);
    push(1, HTRANS_SEQ,    0, 32'h20, HSIZE_WORD, 32'h0);
    run_seq(1);
    check("pipelined_word", ref_word(1, 32'h20), 32'hCAFE5678);

    // Reset asserted while a write to 0x30 is stalled in its wait state.
    hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; hwrite[0] = 1'b1;
    haddr[0] = 32'h30; hsize[0] = HSIZE_WORD; hwdata[0] = 32'h55AA55AA;
    @(posedge clk);
    #1;
    hsel[0] = 1'b0; htrans[0] = HTRANS_IDLE;
    check("rst_mid_wait_stalled", 32'(hreadyout[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(1, HTRANS_NONSEQ, 0, 32'h30, HSIZE_WORD, 32'h0); run_seq(0);

    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 15; b++) begin
        for (int k = 0; k < 10; k++) push_random();
        run_seq(d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave_ctrl.md
Name: ahb_mem_slave_ctrl

Overview:
AHB-Lite slave controller that sequences the byte-addressable data_mem (1 KB, synchronous write, combinational read). It decodes AHB address/data phases, inserts programmable wait states and checks range and alignment. It produces data_mem strobes, handles sub-word writes by read-merge-write, and drives HREADYOUT/HRESP/HRDATA. It sits between the AHB interconnect (decoder/mux) and one data_mem instance.

Parameters:
BASE_ADDR, 32'h0000_0000, AHB byte address mapped to data_mem offset 0
MEM_BYTES, 1024, size of the backing data_mem in bytes; must be a multiple of 4
WAIT_STATES, 1, HREADYOUT-low cycles inserted before every OKAY data phase (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
hsel  in  1  slave select from decoder
haddr  in  32  AHB byte address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write
hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal
hwdata  in  32  write data, valid in data phase
hready  in  1  bus HREADY (previous transfer complete)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data
wr_en_ram  out  1  data_mem write strobe
rd_en_ram  out  1  data_mem read enable
address_ram  out  32  word-aligned data_mem byte offset
store_data  out  32  merged write word
read_data  in  32  data_mem combinational read word

Behaviour:
- Accept: a transfer is accepted on a clk edge where hsel & hready & htrans[1]. On accept, register addr_q, write_q and size_q.
- hsel with IDLE/BUSY, or hsel low: no access. The controller responds zero-wait OKAY.
- Error check at accept:
  - off = haddr - BASE_ADDR; error if off >= MEM_BYTES (unsigned).
  - error if hsize > 2, if half with off[0]=1, or if word with off[1:0]!=0.
- States: IDLE, WAIT, ACCESS, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. On accept: erroneous → ERR1; else WAIT_STATES>0 → WAIT (cnt=WAIT_STATES-1); else → ACCESS.
  - WAIT: hreadyout=0, hresp=0. Decrement cnt; at cnt==0 → ACCESS. No accept is possible because hready is low.
  - ACCESS: hreadyout=1, hresp=0. address_ram={off[31:2],2'b00}, rd_en_ram=1. Next state follows the IDLE accept rules (pipelined back-to-back); with no accept → IDLE.
    - Read: hrdata=read_data.
    - Write: wr_en_ram=1. store_data = read_data with the selected lanes replaced from hwdata. data_mem commits at the closing edge.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. Accept rules as IDLE.
- Lane merge (little-endian):
  - byte at off[1:0]=k replaces bits [8k+7:8k] from the same hwdata lane;
  - half at off[1]=h replaces bits [16h+15:16h];
  - word replaces all 32 bits.
- Outside ACCESS: wr_en_ram=0, rd_en_ram=0, hrdata=0, store_data=0, address_ram holds addr_q-derived value.
- Latency: an OKAY transfer has a data phase of WAIT_STATES+1 cycles. An ERROR transfer has 2 cycles.
- Hazard: a read in the ACCESS immediately following a write ACCESS to the same word returns the new data, because the write commits at the boundary edge. No forwarding is needed.
- Errored transfers never assert wr_en_ram or rd_en_ram. Memory is unchanged.
- Reset (async, any state including WAIT/ACCESS):
  - state=IDLE, cnt=0, addr_q/write_q/size_q=0.
  - Outputs immediately: hreadyout=1, hresp=0, hrdata=0, wr_en_ram=0, rd_en_ram=0, address_ram=0, store_data=0.
  - A write whose ACCESS is cut by reset does not commit.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes;
  - HSIZE codes;
  - HRESP codes;
  - state encoding localparams (IDLE/WAIT/ACCESS/ERR1/ERR2).
- One natural combinational sub-module: ahb_lane_merge (inputs old word, hwdata, size, off[1:0]; output merged word). It is unit-testable on its own.
- The FSM, counter and error check stay in ahb_mem_slave_ctrl.

Test Plan:
- WAIT_STATES=1: NONSEQ word write 0xDEADBEEF at 0x10, then word read 0x10 → each data phase has hreadyout low exactly 1 cycle; hrdata=0xDEADBEEF; hresp=0.
- After the above, byte write hwdata=0xAA000000 at 0x13, then read 0x10 → hrdata=0xAAADBEEF; wr_en_ram pulses once with store_data=0xAAADBEEF.
- Halfword write at 0x11 and word read at 0x400 (MEM_BYTES=1024) → each gives hresp=1 with hreadyout 0 then 1; wr_en_ram/rd_en_ram never assert; a follow-up read of 0x10 is still 0xAAADBEEF.
- WAIT_STATES=0, pipelined: write 0x12345678 to 0x20 immediately followed by read 0x20 (SEQ) → zero wait states; the read data phase returns 0x12345678.
- htrans=BUSY and IDLE with hsel=1 → hreadyout=1, hresp=0, no memory strobes.
- Assert rst_n=0 mid-WAIT of a write to 0x30 (holding 0x0) → outputs reach reset values without a clock edge; after release a read of 0x30 returns 0x00000000.
